// File: rtl/uc_mgr_pkg.sv
// Shared encodings for the processor redundancy manager: FSM states,
// the mode output encoding and the monitor-bit decoder.
package uc_mgr_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PULSE,
        ST_BLANK,
        ST_PROG,
        ST_DEAD
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_PROGRAM = 2'd1,
        MODE_SWITCH  = 2'd2,
        MODE_RECOVER = 2'd3
    } mode_t;

    // {mon1,mon2}: 11 program request, 01 switch request, 00/10 normal
    function automatic mode_t decode_mon(input logic m1, input logic m2);
        case ({m1, m2})
            2'b11:   return MODE_PROGRAM;
            2'b01:   return MODE_SWITCH;
            default: return MODE_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/uc_redundancy_mgr_if.sv
// Bus between the redundancy manager and the processor bank: per-processor
// error/monitor inputs in, enables and selection status out.
interface uc_redundancy_mgr_if #(
    parameter int N_UC = 4
);
    localparam int SEL_W = $clog2(N_UC);

    logic [N_UC-1:0]  error_in;
    logic [N_UC-1:0]  mon1;
    logic [N_UC-1:0]  mon2;
    logic [N_UC-1:0]  uc_en;
    logic [SEL_W-1:0] selected;
    logic [1:0]       mode;
    logic             failover;
    logic             all_failed;

    modport master (
        output error_in, mon1, mon2,
        input  uc_en, selected, mode, failover, all_failed
    );

    modport slave (
        input  error_in, mon1, mon2,
        output uc_en, selected, mode, failover, all_failed
    );
endinterface

// File: rtl/uc_rr_next.sv
// Finds the next healthy processor after cur, ascending with wrap. The
// current index itself is never returned, so none_left means "no other
// healthy processor exists".
module uc_rr_next #(
    parameter int N_UC  = 4,
    parameter int SEL_W = $clog2(N_UC)
) (
    input  logic [SEL_W-1:0] cur,
    input  logic [N_UC-1:0]  failed,
    output logic [SEL_W-1:0] next,
    output logic             none_left
);
    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the nearest healthy candidate wins last
    always_comb begin
        next      = cur;
        none_left = 1'b1;
        idx       = '0;
        for (int k = N_UC - 1; k >= 1; k--) begin
            idx = SEL_W'((int'(cur) + k) % N_UC);
            if (!failed[idx]) begin
                next      = idx;
                none_left = 1'b0;
            end
        end
    end
endmodule

// File: rtl/uc_redundancy_mgr.sv
// Redundancy manager: supervises N_UC processors, retries a local reset on
// the active one, fails over to the next healthy one, honours program and
// switch requests from the active processor's monitor bits. All outputs are
// registered from the next-state values.
module uc_redundancy_mgr
    import uc_mgr_pkg::*;
#(
    parameter int N_UC      = 4,
    parameter int RST_PULSE = 255,
    parameter int MAX_RETRY = 1,
    parameter int BLANK_CYC = 134217727
) (
    input logic                clk,
    input logic                reset,
    uc_redundancy_mgr_if.slave bus
);
    localparam int SEL_W   = $clog2(N_UC);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CNT_MAX = (RST_PULSE > BLANK_CYC) ? RST_PULSE : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                      state, state_nxt;
    logic [SEL_W-1:0]            sel, sel_nxt;
    logic [N_UC-1:0]             failed, failed_nxt;
    logic [N_UC-1:0][RTY_W-1:0]  retry, retry_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic                        sw_prev;

    logic [N_UC-1:0]             uc_en_nxt;
    mode_t                       mode_nxt;
    mode_t                       dec;
    logic                        is_prog, is_sw;
    logic [SEL_W-1:0]            rr_next;
    logic                        rr_none;

    uc_rr_next #(.N_UC(N_UC), .SEL_W(SEL_W)) u_rr (
        .cur       (sel),
        .failed    (failed),
        .next      (rr_next),
        .none_left (rr_none)
    );

    // Only the active processor's monitor pair is looked at
    always_comb begin
        dec     = decode_mon(bus.mon1[sel], bus.mon2[sel]);
        is_prog = (dec == MODE_PROGRAM);
        is_sw   = (dec == MODE_SWITCH);
    end

    // Next-state logic; priority in RUN is program > error > switch
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        failed_nxt = failed;
        retry_nxt  = retry;
        cnt_nxt    = cnt;
        case (state)
            ST_RUN: begin
                if (is_prog) begin
                    state_nxt = ST_PROG;
                end else if (bus.error_in[sel]) begin
                    if (retry[sel] < RTY_W'(MAX_RETRY)) begin
                        retry_nxt[sel] = retry[sel] + RTY_W'(1);
                        state_nxt      = ST_PULSE;
                        cnt_nxt        = '0;
                    end else begin
                        failed_nxt[sel] = 1'b1;
                        if (rr_none) begin
                            state_nxt = ST_DEAD;
                        end else begin
                            sel_nxt            = rr_next;
                            retry_nxt[rr_next] = '0;
                            state_nxt          = ST_BLANK;
                            cnt_nxt            = '0;
                        end
                    end
                end else if (is_sw && !sw_prev && !rr_none) begin
                    // A switch keeps the old processor powered: it is healthy
                    sel_nxt            = rr_next;
                    retry_nxt[rr_next] = '0;
                    state_nxt          = ST_BLANK;
                    cnt_nxt            = '0;
                end
            end
            ST_PULSE: begin
                if (cnt == CNT_W'(RST_PULSE - 1)) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (is_prog) begin
                    state_nxt = ST_PROG;
                end else if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PROG: begin
                if (!is_prog) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end
            end
            ST_DEAD: begin
                state_nxt = ST_DEAD;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Output values implied by the next state
    always_comb begin
        uc_en_nxt = ~failed_nxt;
        mode_nxt  = MODE_NORMAL;
        case (state_nxt)
            ST_PULSE: begin
                uc_en_nxt[sel_nxt] = 1'b0;
                mode_nxt           = MODE_RECOVER;
            end
            ST_BLANK: mode_nxt  = MODE_RECOVER;
            ST_PROG: begin
                uc_en_nxt = '1;
                mode_nxt  = MODE_PROGRAM;
            end
            ST_DEAD:  uc_en_nxt = '0;
            default:  mode_nxt  = is_sw ? MODE_SWITCH : MODE_NORMAL;
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_RUN;
            sel            <= '0;
            failed         <= '0;
            retry          <= '0;
            cnt            <= '0;
            sw_prev        <= 1'b0;
            bus.uc_en      <= '1;
            bus.selected   <= '0;
            bus.mode       <= MODE_NORMAL;
            bus.failover   <= 1'b0;
            bus.all_failed <= 1'b0;
        end else begin
            state          <= state_nxt;
            sel            <= sel_nxt;
            failed         <= failed_nxt;
            retry          <= retry_nxt;
            cnt            <= cnt_nxt;
            sw_prev        <= is_sw;
            bus.uc_en      <= uc_en_nxt;
            bus.selected   <= sel_nxt;
            bus.mode       <= mode_nxt;
            bus.failover   <= (sel_nxt != sel);
            bus.all_failed <= (state_nxt == ST_DEAD);
        end
    end
endmodule

// File: tb/tb_uc_redundancy_mgr.sv
// Bench for uc_redundancy_mgr: directed scenarios against fixed expectations
// plus a randomized run against a countdown-based behavioural model.
module tb_uc_redundancy_mgr;
    localparam int N = 4, P = 4, R = 1, B = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0, failures = 0;

    uc_redundancy_mgr_if #(.N_UC(N)) bus();

    uc_redundancy_mgr #(.N_UC(N), .RST_PULSE(P), .MAX_RETRY(R), .BLANK_CYC(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_sel, m_retry[N], m_pulse_left, m_blank_left;
    bit m_failed[N], m_prog, m_dead, m_prev_sw;
    logic [N-1:0] e_en;
    int e_sel, e_mode;
    bit e_fo, e_af;

    function automatic int pick_next(int cur);
        for (int k = 1; k < N; k++)
            if (!m_failed[(cur + k) % N]) return (cur + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_pulse_left = 0; m_blank_left = 0;
        m_prog = 0; m_dead = 0; m_prev_sw = 0;
        for (int i = 0; i < N; i++) begin m_failed[i] = 0; m_retry[i] = 0; end
        e_en = '1; e_sel = 0; e_mode = 0; e_fo = 0; e_af = 0;
    endtask

    task automatic model_step();
        bit prog, sw, err;
        int old, nx;
        prog = bus.mon1[m_sel] && bus.mon2[m_sel];
        sw   = !bus.mon1[m_sel] && bus.mon2[m_sel];
        err  = bus.error_in[m_sel];
        old  = m_sel;
        if (m_dead) begin
        end else if (m_pulse_left > 0) begin
            m_pulse_left--;
            if (m_pulse_left == 0) m_blank_left = B;
        end else if (m_prog) begin
            if (!prog) begin m_prog = 0; m_blank_left = B; end
        end else if (prog) begin
            m_prog = 1;
        end else if (m_blank_left > 0) begin
            m_blank_left--;
        end else if (err) begin
            if (m_retry[m_sel] < R) begin
                m_retry[m_sel]++;
                m_pulse_left = P;
            end else begin
                m_failed[m_sel] = 1;
                nx = pick_next(m_sel);
                if (nx < 0) m_dead = 1;
                else begin m_sel = nx; m_retry[nx] = 0; m_blank_left = B; end
            end
        end else if (sw && !m_prev_sw) begin
            nx = pick_next(m_sel);
            if (nx >= 0) begin m_sel = nx; m_retry[nx] = 0; m_blank_left = B; end
        end
        m_prev_sw = sw;
        for (int i = 0; i < N; i++) e_en[i] = !m_failed[i];
        if (m_pulse_left > 0) e_en[m_sel] = 1'b0;
        if (m_prog) e_en = '1;
        if (m_dead) e_en = '0;
        if (m_prog) e_mode = 1;
        else if (m_pulse_left > 0 || m_blank_left > 0) e_mode = 3;
        else if (m_dead) e_mode = 0;
        else e_mode = sw ? 2 : 0;
        e_sel = m_sel;
        e_fo  = (m_sel != old);
        e_af  = m_dead;
    endtask

    // One clock: model follows the same edge, outputs sampled on the negedge
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        bus.error_in = '0; bus.mon1 = '0; bus.mon2 = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.uc_en !== 4'b1111) begin failures++; $display("FAIL reset_uc_en got=%b want=1111", bus.uc_en); end
        checks++; if (bus.selected !== 2'd0) begin failures++; $display("FAIL reset_selected got=%0d want=0", bus.selected); end
        checks++; if (bus.mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d want=0", bus.mode); end
        checks++; if (bus.all_failed !== 1'b0 || bus.failover !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", bus.all_failed, bus.failover); end
    endtask

    task automatic test_retry_pulse();
        int low = 0, rec = 0, fo = 0;
        bit sel_moved = 0;
        bus.error_in = 4'b0001;
        for (int i = 0; i < P + B + 4; i++) begin
            tick();
            if (!bus.uc_en[0]) low++;
            if (bus.mode == 2'd3) rec++;
            if (bus.failover) fo++;
            if (bus.selected != 2'd0) sel_moved = 1;
            // errors on the selected processor while blanking, incl. the last blank edge
            bus.error_in = (i == P + 1 || i == P + B - 1) ? 4'b0001 : 4'b0000;
        end
        checks++; if (low != P) begin failures++; $display("FAIL pulse_len got=%0d want=%0d", low, P); end
        checks++; if (rec != P + B) begin failures++; $display("FAIL recover_len got=%0d want=%0d", rec, P + B); end
        checks++; if (sel_moved || fo != 0) begin failures++; $display("FAIL blank_ignore got_moved=%0b fo=%0d want=0", sel_moved, fo); end
        checks++; if (bus.uc_en !== 4'b1111 || bus.mode !== 2'd0) begin failures++; $display("FAIL after_blank got_en=%b mode=%0d want=1111/0", bus.uc_en, bus.mode); end
    endtask

    task automatic test_failover();
        bus.error_in = 4'b0001;
        tick();
        bus.error_in = '0;
        checks++; if (bus.selected !== 2'd1) begin failures++; $display("FAIL fo_selected got=%0d want=1", bus.selected); end
        checks++; if (bus.failover !== 1'b1) begin failures++; $display("FAIL fo_pulse got=%b want=1", bus.failover); end
        checks++; if (bus.uc_en !== 4'b1110) begin failures++; $display("FAIL fo_uc_en got=%b want=1110", bus.uc_en); end
        tick();
        checks++; if (bus.failover !== 1'b0) begin failures++; $display("FAIL fo_one_cycle got=%b want=0", bus.failover); end
        repeat (B - 1) tick();
        checks++; if (bus.mode !== 2'd0) begin failures++; $display("FAIL fo_blank_end got=%0d want=0", bus.mode); end
    endtask

    task automatic test_program();
        int rec, fo = 0;
        bus.mon1 = 4'b0010; bus.mon2 = 4'b0010; bus.error_in = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.failover) fo++;
            checks++; if (bus.uc_en !== 4'b1111 || bus.mode !== 2'd1) begin failures++; $display("FAIL prog_state got_en=%b mode=%0d want=1111/1", bus.uc_en, bus.mode); end
        end
        checks++; if (fo != 0 || bus.selected !== 2'd1) begin failures++; $display("FAIL prog_no_fo got_fo=%0d sel=%0d want=0/1", fo, bus.selected); end
        bus.mon1 = '0; bus.mon2 = '0; bus.error_in = '0;
        tick();
        checks++; if (bus.uc_en !== 4'b1110) begin failures++; $display("FAIL prog_exit_en got=%b want=1110", bus.uc_en); end
        rec = (bus.mode == 2'd3) ? 1 : 0;
        repeat (12) begin tick(); if (bus.mode == 2'd3) rec++; end
        checks++; if (rec != B) begin failures++; $display("FAIL prog_blank_len got=%0d want=%0d", rec, B); end
    endtask

    task automatic test_switch();
        int fo = 0;
        bus.mon1 = '0; bus.mon2 = '1;
        repeat (20) begin tick(); if (bus.failover) fo++; end
        checks++; if (fo != 1) begin failures++; $display("FAIL switch_count got=%0d want=1", fo); end
        checks++; if (bus.selected !== 2'd2) begin failures++; $display("FAIL switch_sel got=%0d want=2", bus.selected); end
        checks++; if (bus.mode !== 2'd2) begin failures++; $display("FAIL switch_mode got=%0d want=2", bus.mode); end
        bus.mon2 = '0;
        repeat (2) tick();
    endtask

    task automatic test_dead();
        int n;
        for (int it = 0; it < 12 && !bus.all_failed; it++) begin
            bus.error_in = '1;
            tick();
            bus.error_in = '0;
            n = 0;
            while (bus.mode != 2'd0 && !bus.all_failed && n < 40) begin tick(); n++; end
            checks++; if (n >= 40) begin failures++; $display("FAIL dead_wait got=timeout want=run"); end
        end
        checks++; if (bus.all_failed !== 1'b1) begin failures++; $display("FAIL dead_flag got=%b want=1", bus.all_failed); end
        checks++; if (bus.uc_en !== 4'b0000) begin failures++; $display("FAIL dead_uc_en got=%b want=0000", bus.uc_en); end
        checks++; if (bus.selected !== 2'd1) begin failures++; $display("FAIL dead_sel got=%0d want=1", bus.selected); end
        reset = 1'b0; tick(); reset = 1'b1; tick();
        bus.error_in = 4'b0001; tick(); bus.error_in = '0;
        repeat (2) tick();
        checks++; if (bus.uc_en !== 4'b1110) begin failures++; $display("FAIL mid_pulse_en got=%b want=1110", bus.uc_en); end
        reset = 1'b0; tick();
        checks++; if (bus.uc_en !== 4'b1111 || bus.selected !== 2'd0) begin failures++; $display("FAIL mid_pulse_reset got_en=%b sel=%0d want=1111/0", bus.uc_en, bus.selected); end
        checks++; if (bus.all_failed !== 1'b0 || bus.mode !== 2'd0) begin failures++; $display("FAIL mid_pulse_reset_flags got_af=%b mode=%0d want=0/0", bus.all_failed, bus.mode); end
        reset = 1'b1; tick();
    endtask

    task automatic test_random();
        int r;
        bus.error_in = '0; bus.mon1 = '0; bus.mon2 = '0;
        reset = 1'b0; tick(); reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    r = $urandom_range(0, 7);
                    bus.mon1[i] = (r == 5 || r == 6);
                    bus.mon2[i] = (r == 6 || r == 7);
                end
                bus.error_in[i] = ($urandom_range(0, 11) == 0);
            end
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++; if (bus.uc_en !== e_en) begin failures++; $display("FAIL rnd_uc_en cyc=%0d got=%b want=%b", c, bus.uc_en, e_en); end
            checks++; if (bus.selected !== 2'(e_sel)) begin failures++; $display("FAIL rnd_sel cyc=%0d got=%0d want=%0d", c, bus.selected, e_sel); end
            checks++; if (bus.mode !== 2'(e_mode)) begin failures++; $display("FAIL rnd_mode cyc=%0d got=%0d want=%0d", c, bus.mode, e_mode); end
            checks++; if (bus.failover !== e_fo) begin failures++; $display("FAIL rnd_failover cyc=%0d got=%b want=%b", c, bus.failover, e_fo); end
            checks++; if (bus.all_failed !== e_af) begin failures++; $display("FAIL rnd_all_failed cyc=%0d got=%b want=%b", c, bus.all_failed, e_af); end
        end
    endtask

    initial begin
        bus.error_in = '0; bus.mon1 = '0; bus.mon2 = '0;
        model_reset();
        test_reset();
        test_retry_pulse();
        test_failover();
        test_program();
        test_switch();
        test_dead();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
